// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between the 16 requesters and the round-robin arbiter.
// slave = arbiter side, master = requester side.
interface rr_arbiter_16_if;
  logic [15:0] req;
  logic        release_i;
  logic [15:0] grant;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic        timeout;

  modport slave (
    input  req,
    input  release_i,
    output grant,
    output grant_valid,
    output grant_idx,
    output timeout
  );

  modport master (
    output req,
    output release_i,
    input  grant,
    input  grant_valid,
    input  grant_idx,
    input  timeout
  );
endinterface

// File: rtl/rr_arbiter_16.sv
// 16-port round-robin arbiter: one-cycle request-to-grant latency, grant held until release or HOLD_MAX cycles.
// No backpressure: req is only looked at in IDLE; the holder frees the grant via release_i or the timeout.
module rr_arbiter_16 #(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_16_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_MAX - 1);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] grant_q, grant_d;
  logic [3:0]  grant_idx_q, grant_idx_d;
  logic        grant_valid_q, grant_valid_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  winner;
  logic        found;

  // First requester at or above ptr, wrapping 15 -> 0.
  always_comb begin
    winner = 4'd0;
    found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && bus.req[ptr_q + 4'(i)]) begin
        found  = 1'b1;
        winner = ptr_q + 4'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = HOLD;
          hold_cnt_d    = 8'd0;
          grant_d       = 16'h0001 << winner;
          grant_idx_d   = winner;
          grant_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.release_i || (hold_cnt_q == LAST_CNT)) begin
          // A release on the timeout cycle wins: no timeout pulse.
          state_d       = IDLE;
          ptr_d         = grant_idx_q + 4'd1;
          grant_d       = 16'h0000;
          grant_idx_d   = 4'd0;
          grant_valid_d = 1'b0;
          timeout_d     = !bus.release_i;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 4'd0;
      hold_cnt_q    <= 8'd0;
      grant_q       <= 16'h0000;
      grant_idx_q   <= 4'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16 (HOLD_MAX=4): directed grant sequences feed an expected-grant queue,
// a negedge monitor pops and checks each grant's index, visible length and timeout flag.
module tb_rr_arbiter_16;

  localparam int HM = 4;

  typedef struct {
    logic [3:0] idx;
    int         len;
    logic       to;
  } exp_t;

  logic clk;
  logic rst;
  rr_arbiter_16_if bus ();

  rr_arbiter_16 #(.HOLD_MAX(HM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  bit   prev_vld = 1'b0;
  int   vis_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.grant_valid === 1'b1) begin
        chk("onehot", 32'(bus.grant), 32'(16'h0001 << bus.grant_idx));
        if (!prev_vld) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_grant: got idx=%0d expected no grant at %0t", bus.grant_idx, $time);
          end else begin
            cur = exp_q.pop_front();
            chk("grant_idx", 32'(bus.grant_idx), 32'(cur.idx));
          end
          vis_cnt = 1;
        end else begin
          vis_cnt++;
          chk("grant_stable", 32'(bus.grant_idx), 32'(cur.idx));
        end
        chk("timeout_in_hold", 32'(bus.timeout), 32'd0);
      end else begin
        chk("idle_grant", 32'(bus.grant), 32'd0);
        chk("idle_idx", 32'(bus.grant_idx), 32'd0);
        chk("idle_valid", 32'(bus.grant_valid), 32'd0);
        if (prev_vld) begin
          chk("hold_len", 32'(vis_cnt), 32'(cur.len));
          chk("timeout_pulse", 32'(bus.timeout), 32'(cur.to));
        end else begin
          chk("idle_timeout", 32'(bus.timeout), 32'd0);
        end
      end
      prev_vld = (bus.grant_valid === 1'b1);
    end
  end

  // Request, hold for 'hold' visible cycles, then release.
  task automatic grant_rel(input logic [15:0] r, input logic [3:0] idx, input int hold, input bit drop);
    exp_q.push_back('{idx: idx, len: hold, to: 1'b0});
    bus.req = r;
    @(posedge clk); #2;
    if (drop) bus.req = 16'h0000;
    repeat (hold - 1) @(posedge clk);
    #2 bus.release_i = 1'b1;
    @(posedge clk); #2;
    bus.release_i = 1'b0;
    bus.req = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 16'h0000;
    bus.release_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 16'h0000;
    bus.release_i = 1'b0;
    @(posedge clk); #2;
    mon_en = 1'b1;
    do_reset();
    @(posedge clk); #2;

    // Basic grant/release of port 0.
    grant_rel(16'h0001, 4'd0, 1, 1'b0);
    // release_i while idle must not move anything.
    bus.release_i = 1'b1;
    repeat (2) @(posedge clk);
    #2 bus.release_i = 1'b0;

    // Fairness with a constant request set, starting from a fresh pointer.
    do_reset();
    grant_rel(16'h8003, 4'd0, 1, 1'b0);
    grant_rel(16'h8003, 4'd1, 1, 1'b0);
    grant_rel(16'h8003, 4'd15, 1, 1'b0);
    grant_rel(16'h8003, 4'd0, 1, 1'b0);
    grant_rel(16'h8003, 4'd1, 1, 1'b0);

    // Wrap: ptr=15 after granting 14, then port 0 wins over 14.
    grant_rel(16'h4000, 4'd14, 2, 1'b0);
    // Release on the same cycle the timeout would fire: plain release.
    grant_rel(16'h4001, 4'd0, HM, 1'b0);

    // Timeout of port 3 with release held low.
    exp_q.push_back('{idx: 4'd3, len: HM, to: 1'b1});
    bus.req = 16'h0008;
    @(posedge clk); #2;
    bus.req = 16'h0000;
    repeat (HM) @(posedge clk);
    #2;
    // ptr must now be 4: port 4 beats port 3.
    grant_rel(16'h0018, 4'd4, 1, 1'b0);

    // Reset in the middle of a hold on port 5.
    exp_q.push_back('{idx: 4'd5, len: 2, to: 1'b0});
    bus.req = 16'h0020;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    bus.req = 16'h0000;
    grant_rel(16'h0021, 4'd0, 1, 1'b0);

    // Holder drops req; grant must persist until release.
    grant_rel(16'h0004, 4'd2, 3, 1'b1);

    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 255, meaning the maximum number of cycles a grant is held before it is forcibly revoked (legal range 1..255).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req  input  16  per-port request; bit i is the request from port i; sampled only in IDLE.
REQ-006 release_i  input  1  current grant holder is finished; honoured only while grant_valid=1.
REQ-007 grant  output  16  registered one-hot grant vector; all zero when grant_valid=0; feeds the downstream 16-to-4 index encoder.
REQ-008 grant_valid  output  1  registered; high while a grant is held.
REQ-009 grant_idx  output  4  registered binary index of the set bit of grant; 0 when grant_valid=0.
REQ-010 timeout  output  1  registered single-cycle pulse; a grant was forcibly revoked.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (no grant) and HOLD (grant held).
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with all outputs low or zero.
REQ-013 In IDLE with req!=0 at edge N, the winner SHALL be the first set req bit found by scanning upward from ptr, wrapping 15->0; the FSM enters HOLD and the outputs take the following values from edge N+1: grant=1<<winner, grant_idx=winner, grant_valid=1.
REQ-014 The arbitration latency SHALL be exactly one cycle from a sampled request to a visible grant.
REQ-015 ptr is a 4-bit internal register, reset to 0.
REQ-016 On every exit from HOLD, ptr SHALL become (grant_idx+1) mod 16; 15 wraps to 0.
REQ-017 In HOLD, req SHALL be ignored; grant and grant_idx SHALL stay stable even if the holder deasserts req.
REQ-018 hold_cnt is an 8-bit counter, cleared on HOLD entry, incremented on each HOLD cycle without an exit.
REQ-019 In HOLD, release_i=1 at an edge SHALL cause a return to IDLE; from the next cycle grant=0, grant_idx=0 and grant_valid=0.
REQ-020 In HOLD with release_i=0 and hold_cnt==HOLD_MAX-1 at an edge, the block SHALL revoke the grant as in REQ-019 and pulse timeout=1 for exactly the next cycle.
REQ-021 release_i and timeout coinciding SHALL be treated as a normal release with no timeout pulse.
REQ-022 release_i asserted in IDLE SHALL have no effect.
REQ-023 After any exit from HOLD, at least one IDLE cycle SHALL occur before the next grant, so back-to-back grants are spaced by at least 2 cycles.
REQ-024 At most one grant bit SHALL ever be set, and grant_idx SHALL always equal the index of that bit.

Reset
REQ-025 rst=1 at an edge SHALL force from the next cycle: state=IDLE, ptr=0, hold_cnt=0, grant=0, grant_idx=0, grant_valid=0, timeout=0.
REQ-026 rst SHALL take priority over req and release_i, including reset asserted mid-HOLD; no timeout pulse results.
REQ-027 The first arbitration after reset SHALL start its scan at port 0.

Verification
REQ-028 Reset, then req=16'h0001 -> next cycle grant=16'h0001, grant_idx=0, grant_valid=1; release_i=1 -> next cycle all zero, ptr=1.
REQ-029 Fairness: req=16'h8003 held constant, release_i=1 one cycle after each grant -> grant order 0,1,15,0,1,... and grant_idx matches each time.
REQ-030 Wrap: ptr=15 (after granting 14), req=16'h4001 -> grant_idx=0, not 14.
REQ-031 Timeout: HOLD_MAX=4, grant port 3, release_i=0 -> grant visible for exactly 4 cycles, timeout=1 for 1 cycle, then ptr=4.
REQ-032 Reset mid-HOLD: port 5 granted, rst=1 -> next cycle all outputs zero, timeout=0; req=16'h0021 then -> grant_idx=0.
REQ-033 Holder drops req during HOLD -> grant unchanged until release_i or timeout; release_i in IDLE -> no output change.
